// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq -- iterative 32-bit restoring divider with a four-state FSM.
//
// One quotient bit is resolved per clock in the ON state. A nonzero-divisor
// request accepted at rising edge k enters END at edge k+32, so ready_o is
// seen high from edge k+33. A zero divisor goes IDLE -> DIVZERO -> END and
// returns an all-zero result, with ready_o seen high from edge k+2.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   start_i    division request, held high until ready_o is seen
//   signed_i   1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i
//   opdata1_i  dividend, sampled with start_i
//   opdata2_i  divisor, sampled with start_i
//   annul_i    flush: any state returns to IDLE at the next edge
//   result_o   {remainder, quotient}; forced to zero while ready_o = 0
//   ready_o    result valid (state END)
//   stallreq   combinational request to hold the upstream pipeline
//
// Build option:
//   DIV_SIGNED_EN  when defined, signed_i is honoured (absolute-value
//                  operands plus quotient/remainder sign fix). When
//                  undefined, every division is unsigned and no sign
//                  logic is built.
// ---------------------------------------------------------------------------
module div_seq #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DIVZERO = 2'd1;
  localparam logic [1:0] S_ON      = 2'd2;
  localparam logic [1:0] S_END     = 2'd3;

  // Step index of the final (32nd) restoring step.
  localparam logic [5:0] LAST_STEP = 6'(DATA_W - 1);

  logic [1:0]            state;
  logic [5:0]            cnt;
  logic [2*DATA_W:0]     work;
  logic [DATA_W-1:0]     divisor;
  logic [2*DATA_W-1:0]   result_r;

  logic                  accept;
  logic [DATA_W:0]       diff;
  logic [2*DATA_W:0]     work_step;
  logic [DATA_W-1:0]     dividend_mag;
  logic [DATA_W-1:0]     divisor_mag;
  logic [DATA_W-1:0]     quot_fix;
  logic [DATA_W-1:0]     rem_fix;

  assign accept = (state == S_IDLE) && start_i && !annul_i;

  // One restoring step: trial-subtract the divisor from the upper half of
  // the working register. A borrow (diff[DATA_W]) means the divisor did not
  // fit, so the partial remainder is kept and just shifted; otherwise the
  // difference replaces it and a 1 quotient bit is shifted in at the bottom.
  assign diff      = work[2*DATA_W:DATA_W] - {1'b0, divisor};
  assign work_step = diff[DATA_W] ? {work[2*DATA_W-1:0], 1'b0}
                                  : {diff[DATA_W-1:0], work[DATA_W-1:0], 1'b1};

`ifdef DIV_SIGNED_EN
  logic neg_quot;
  logic neg_rem;

  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
    return (~v) + DATA_W'(1);
  endfunction

  // Two's-complement magnitude. For the most negative value the negation
  // wraps back to 0x80000000, which is exactly the correct magnitude when
  // read as unsigned, so no special case is needed.
  function automatic logic [DATA_W-1:0] magnitude(
    input logic signed [DATA_W-1:0] v,
    input logic                     is_signed
  );
    return (is_signed && (v < 0)) ? negate(v) : v;
  endfunction

  assign dividend_mag = magnitude(opdata1_i, signed_i);
  assign divisor_mag  = magnitude(opdata2_i, signed_i);

  // Sign fix is taken from the post-step working value so it lands in the
  // same edge that enters END.
  assign quot_fix = neg_quot ? negate(work_step[DATA_W-1:0])
                             : work_step[DATA_W-1:0];
  assign rem_fix  = neg_rem  ? negate(work_step[2*DATA_W:DATA_W+1])
                             : work_step[2*DATA_W:DATA_W+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
    end else if (accept && (opdata2_i != '0)) begin
      neg_quot <= signed_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
      neg_rem  <= signed_i && opdata1_i[DATA_W-1];
    end
  end
`else
  logic unused_signed;

  assign unused_signed = signed_i;
  assign dividend_mag  = opdata1_i;
  assign divisor_mag   = opdata2_i;
  assign quot_fix      = work_step[DATA_W-1:0];
  assign rem_fix       = work_step[2*DATA_W:DATA_W+1];
`endif

  // Control FSM plus the working registers it owns.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      work    <= '0;
      divisor <= '0;
    end else if (annul_i) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            if (opdata2_i == '0) begin
              state <= S_DIVZERO;
            end else begin
              state   <= S_ON;
              work    <= {{DATA_W{1'b0}}, dividend_mag, 1'b0};
              divisor <= divisor_mag;
              cnt     <= '0;
            end
          end
        end
        S_DIVZERO: begin
          state <= S_END;
        end
        S_ON: begin
          work <= work_step;
          cnt  <= cnt + 6'd1;
          if (cnt == LAST_STEP) begin
            state <= S_END;
          end
        end
        S_END: begin
          // Holding start_i keeps the result on the bus; no restart here.
          if (!start_i) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Result capture. Only observed through the END gate below, so it needs
  // no reset of its own.
  always_ff @(posedge clk) begin
    if (state == S_DIVZERO) begin
      result_r <= '0;
    end else if ((state == S_ON) && (cnt == LAST_STEP)) begin
      result_r <= {rem_fix, quot_fix};
    end
  end

  assign ready_o  = (state == S_END);
  assign result_o = ready_o ? result_r : '0;
  assign stallreq = accept || (state == S_DIVZERO) || (state == S_ON);

endmodule

// File: tb/tb_div_seq.sv
// ---------------------------------------------------------------------------
// tb_div_seq -- self-checking bench for div_seq.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// "n" below is the number of rising edges since (and including) the edge that
// accepted the request, so a value seen at n = 33 is the value seen at
// edge k+33.
// ---------------------------------------------------------------------------
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sgn_in;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stall;

  int errors = 0;
  int checks = 0;

  logic [63:0] sb[$];

  div_seq #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .signed_i  (sgn_in),
    .opdata1_i (op1),
    .opdata2_i (op2),
    .annul_i   (annul),
    .result_o  (result),
    .ready_o   (ready),
    .stallreq  (stall)
  );

  always #5 clk = ~clk;

  // Reference division built from plain integer arithmetic on magnitudes.
  function automatic logic [63:0] exp_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s_in);
    logic        s;
    logic [31:0] ma, mb, q, r;
`ifdef DIV_SIGNED_EN
    s = s_in;
`else
    s = 1'b0 & s_in;
`endif
    if (b == 32'd0) return 64'd0;
    ma = (s && a[31]) ? (32'd0 - a) : a;
    mb = (s && b[31]) ? (32'd0 - b) : b;
    q  = ma / mb;
    r  = ma % mb;
    if (s && (a[31] ^ b[31])) q = 32'd0 - q;
    if (s && a[31])           r = 32'd0 - r;
    return {r, q};
  endfunction

  // Drives one request (called on a falling edge) and waits for ready.
  // n = -1 on timeout. pend_ok is cleared if stallreq dropped or result_o was
  // nonzero while the result was pending. start stays high on return.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output int n, output logic [63:0] res, output logic pend_ok);
    op1 = a; op2 = b; sgn_in = s; start = 1'b1;
    n = 0; res = '0; pend_ok = 1'b1;
    #1;
    if (stall !== 1'b1) pend_ok = 1'b0;
    forever begin
      @(negedge clk);
      n++;
      if (ready === 1'b1) break;
      if (stall !== 1'b1 || result !== 64'd0) pend_ok = 1'b0;
      if (n >= 60) begin n = -1; break; end
    end
    if (n > 0) res = result;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; annul = 1'b0; sgn_in = 1'b0; op1 = '0; op2 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (ready !== 1'b0 || result !== 64'd0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b result=%h stall=%b, required 0/0/0",
               ready, result, stall);
    end
    rst = 1'b0;
  endtask

  // Generic transaction with scoreboard push/pop and latency check.
  task automatic do_one(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int lat_req);
    int n; logic [63:0] res, expv; logic pend_ok;
    sb.push_back(exp_div(a, b, s));
    run_div(a, b, s, n, res, pend_ok);
    expv = sb.pop_front();
    checks++;
    if (n != lat_req) begin
      errors++;
      $display("FAIL %s_latency: got %0d, required %0d", name, n, lat_req);
    end
    checks++;
    if (res !== expv) begin
      errors++;
      $display("FAIL %s_result: got %h, required %h", name, res, expv);
    end
    checks++;
    if (pend_ok !== 1'b1) begin
      errors++;
      $display("FAIL %s_pending: stall/result while busy wrong (flag=%b), required 1", name, pend_ok);
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    int n; logic [63:0] res; logic pend_ok;
    sb.push_back({32'd2, 32'd14});
    run_div(32'd100, 32'd7, 1'b0, n, res, pend_ok);
    checks++;
    if (n != 33) begin
      errors++; $display("FAIL u100_7_latency: got %0d, required 33", n);
    end
    checks++;
    if (res !== sb[0]) begin
      errors++; $display("FAIL u100_7_result: got %h, required %h", res, sb[0]);
    end
    void'(sb.pop_front());
    checks++;
    if (pend_ok !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL u100_7_stall: pend_ok=%b stall_in_end=%b, required 1/0", pend_ok, stall);
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      errors++; $display("FAIL u100_7_idle: ready=%b result=%h, required 0/0", ready, result);
    end
    do_one("u_max_1",   32'hFFFF_FFFF, 32'd1,         1'b0, 33);
    do_one("u_small_big", 32'd5,       32'hFFFF_FFFF, 1'b0, 33);
    do_one("u_big_big", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
  endtask

  task automatic test_signed();
    int n; logic [63:0] res, expv; logic pend_ok;
`ifdef DIV_SIGNED_EN
    expv = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
`else
    expv = {32'h0000_0001, 32'h7FFF_FFFC};
`endif
    sb.push_back(expv);
    run_div(32'hFFFF_FFF9, 32'h2, 1'b1, n, res, pend_ok);
    expv = sb.pop_front();
    checks++;
    if (res !== expv || n != 33) begin
      errors++;
      $display("FAIL s_m7_2: got %h at n=%0d, required %h at n=33", res, n, expv);
    end
    start = 1'b0;
    @(negedge clk);
    do_one("s_min_m1",  32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33);
    do_one("s_min_1",   32'h8000_0000, 32'd1,         1'b1, 33);
    do_one("s_7_m2",    32'd7,         32'hFFFF_FFFE, 1'b1, 33);
    do_one("s_m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 33);
  endtask

  task automatic test_divzero();
    do_one("zero_u", 32'd5, 32'd0, 1'b0, 2);
    do_one("zero_s", 32'hFFFF_FFFB, 32'd0, 1'b1, 2);
  endtask

  task automatic test_annul();
    logic seen; logic quiet;
    op1 = 32'd100; op2 = 32'd7; sgn_in = 1'b0; start = 1'b1;
    seen = 1'b0; quiet = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    annul = 1'b1;
    @(negedge clk);
    if (ready) seen = 1'b1;
    start = 1'b0; annul = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ready !== 1'b0 || stall !== 1'b0 || result !== 64'd0) quiet = 1'b0;
    end
    checks++;
    if (seen !== 1'b0 || quiet !== 1'b1) begin
      errors++;
      $display("FAIL annul_quiet: ready_seen=%b quiet=%b, required 0/1", seen, quiet);
    end
    do_one("after_annul_9_3", 32'd9, 32'd3, 1'b0, 33);
  endtask

  task automatic test_reset_mid();
    op1 = 32'd100; op2 = 32'd7; sgn_in = 1'b0; start = 1'b1;
    for (int i = 1; i <= 5; i++) @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || result !== 64'd0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: ready=%b result=%h stall=%b, required 0/0/0",
               ready, result, stall);
    end
    rst = 1'b0;
    do_one("after_reset_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 33);
  endtask

  task automatic test_end_hold();
    int n; logic [63:0] res, expv; logic pend_ok; logic held;
    sb.push_back(exp_div(32'd1000, 32'd33, 1'b0));
    run_div(32'd1000, 32'd33, 1'b0, n, res, pend_ok);
    expv = sb.pop_front();
    checks++;
    if (res !== expv || n != 33) begin
      errors++; $display("FAIL hold_first: got %h at n=%0d, required %h at n=33", res, n, expv);
    end
    held = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ready !== 1'b1 || result !== expv || stall !== 1'b0) held = 1'b0;
    end
    checks++;
    if (held !== 1'b1) begin
      errors++; $display("FAIL hold_stable: stable=%b, required 1", held);
    end
    start = 1'b0;
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ready !== 1'b0 || stall !== 1'b0) held = 1'b0;
    end
    checks++;
    if (held !== 1'b1) begin
      errors++; $display("FAIL hold_release: idle_ok=%b, required 1", held);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic s;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = (i == 0) ? 32'd3 : ($urandom >> $urandom_range(0, 28));
      if (b == 32'd0) b = 32'd1;
      s = 1'(i % 2);
      do_one("b2b", a, b, s, 33);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_divzero();
    test_annul();
    test_reset_mid();
    test_end_hold();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
